// File: rtl/rx_spart.sv
// rx_spart: receive half of the SPART.
// Deserialises 8N1 frames arriving on rxd into rx_buf. Every decision is taken
// on brg_full ticks that arrive at OVERSAMPLE x baud, with each bit sampled at
// its midpoint. The received byte is presented on databus for a processor read.
//
// Read handshake: rda acts as "valid". A read strobe (rd_sel) on any clk is the
// "ready/accept". databus carries rx_buf combinationally while rd_sel is high.
// On the following posedge rda, ovr and ferr clear. If a byte completes on that
// same edge, the completion wins: rda stays 1, rx_buf takes the new byte and
// ovr stays 0, because the old byte was consumed by the read.
module rx_spart #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       brg_full,
    input  logic       rxd,
    output logic       rda,
    output logic       ferr,
    output logic       ovr
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [TW-1:0]          tick_cnt;
    logic [TW-1:0]          tick_d;
    logic [BW-1:0]          bit_cnt;
    logic [BW-1:0]          bit_d;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_d;
    logic [DATA_BITS-1:0]   rx_buf;
    logic                   rxd_m;
    logic                   rxd_s;
    logic                   done;
    logic                   frame_err;
    logic                   rd_sel;
    logic [7:0]             rd_data;

    assign rd_sel  = iocs & iorw & (ioaddr == 2'b00);
    assign rd_data = 8'(rx_buf);
    assign databus = rd_sel ? rd_data : 8'hzz;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame sequencing: next state, counters, shift register and frame events.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_cnt;
        bit_d     = bit_cnt;
        shreg_d   = shreg;
        done      = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Falling edge is detected on any clk; tick counting starts afresh.
                tick_d = '0;
                if (!rxd_s) state_d = S_START;
            end
            S_START: begin
                if (brg_full) begin
                    if (tick_cnt == HALF_LAST) begin
                        // Mid start bit: a high line here means a glitch, not a frame.
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (brg_full) begin
                    if (tick_cnt == FULL_LAST) begin
                        // LSB arrives first, so shift in from the MSB side.
                        tick_d  = '0;
                        shreg_d = (shreg >> 1) | (DATA_BITS'(rxd_s) << (DATA_BITS - 1));
                        if (bit_cnt == BIT_LAST) state_d = S_STOP;
                        else bit_d = bit_cnt + BW'(1);
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (brg_full) begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_d = '0;
                        if (rxd_s) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_cnt + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before a new start is accepted.
                if (rxd_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and shift-register storage; reset aborts any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state_q  <= state_d;
            tick_cnt <= tick_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
        end
    end

    // Receive buffer and status flags; a byte completion takes priority over a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf <= '0;
            rda    <= 1'b0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (done) begin
                rx_buf <= shreg;
                rda    <= 1'b1;
                ovr    <= rda & ~rd_sel;
            end else if (rd_sel) begin
                rda <= 1'b0;
                ovr <= 1'b0;
            end
            if (frame_err) ferr <= 1'b1;
            else if (rd_sel) ferr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_spart.sv
// tb_rx_spart: serial-line driver plus register-level reference model for rx_spart.
// The model tracks what the processor should see (buffer, rda, ferr, ovr) purely
// from which frames were sent and when reads happened. Each read pushes its
// expected view into exp_q, and a monitor pops and compares while the read strobe is up.
module tb_rx_spart;

    localparam int OS  = 16;
    localparam int DIV = 4;
    localparam int STOP_SAMPLE = OS / 2 + 9 * OS;  // tick index of the stop-bit midpoint

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       brg_full;
    logic       rxd;
    logic       rda;
    logic       ferr;
    logic       ovr;
    tri1  [7:0] databus;

    int checks   = 0;
    int failures = 0;
    int brg_cnt  = 0;

    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic [7:0]  exp_buf;
    logic        exp_rda;
    logic        exp_ferr;
    logic        exp_ovr;

    rx_spart #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .brg_full (brg_full),
        .rxd      (rxd),
        .rda      (rda),
        .ferr     (ferr),
        .ovr      (ovr)
    );

    // Clock and reset block: free-running clock, baud tick every DIV clocks.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (brg_cnt == DIV - 1) begin
            brg_cnt  = 0;
            brg_full = 1'b1;
        end else begin
            brg_cnt  = brg_cnt + 1;
            brg_full = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rda"},  {31'd0, rda},  {31'd0, exp_rda});
        check({tag, "_ferr"}, {31'd0, ferr}, {31'd0, exp_ferr});
        check({tag, "_ovr"},  {31'd0, ovr},  {31'd0, exp_ovr});
    endtask

    // Reference model: register view as a function of frames and reads.
    task automatic model_reset();
        exp_buf  = 8'h00;
        exp_rda  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic model_good(input logic [7:0] d);
        exp_ovr = exp_rda;
        exp_rda = 1'b1;
        exp_buf = d;
    endtask

    task automatic model_read();
        exp_q.push_back({exp_buf, exp_rda, exp_ferr, exp_ovr});
        exp_rda  = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Driver tasks.
    task automatic wait_tick();
        do @(posedge clk); while (!brg_full);
    endtask

    // Sends one frame aligned to baud ticks. hold_low extends a low stop bit
    // into a break; read_tick raises a read on the clk of that tick; rst_tick
    // pulses reset just after that tick (0 disables either option).
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int hold_low,
                              input int read_tick, input int rst_tick);
        int  last;
        int  idx;
        bit  aborted;
        bit  reading;
        aborted = 1'b0;
        reading = 1'b0;
        last    = 10 * OS + hold_low;
        wait_tick();
        @(negedge clk);
        rxd = 1'b0;
        for (int tk = 1; tk <= last; tk++) begin
            wait_tick();
            @(negedge clk);
            if (reading) begin
                iocs    = 1'b0;
                reading = 1'b0;
            end
            if (tk == last) begin
                rxd = 1'b1;
            end else if (tk % OS == 0) begin
                idx = tk / OS;
                if (idx <= 8) rxd = d[idx-1];
                else rxd = stop_ok;
            end
            if (tk == STOP_SAMPLE && !aborted) begin
                if (stop_ok) model_good(d);
                else exp_ferr = 1'b1;
                if (read_tick == STOP_SAMPLE) check_flags("stop_read_post");
            end
            if (tk == rst_tick) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                model_reset();
            end
            if (tk + 1 == read_tick) begin
                repeat (DIV - 1) @(negedge clk);
                model_read();
                iocs    = 1'b1;
                iorw    = 1'b1;
                ioaddr  = 2'b00;
                reading = 1'b1;
            end
        end
        repeat ($urandom_range(1, 6)) wait_tick();
    endtask

    task automatic send_glitch(input int low_ticks);
        wait_tick();
        @(negedge clk);
        rxd = 1'b0;
        repeat (low_ticks) wait_tick();
        @(negedge clk);
        rxd = 1'b1;
        repeat (12) wait_tick();
    endtask

    task automatic do_read();
        @(negedge clk);
        model_read();
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        @(negedge clk);
        iocs = 1'b0;
        check_flags("post_read");
    endtask

    // Writes, other addresses and deselected reads must leave bus and flags alone.
    task automatic poke_ignored();
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00;
        #1 check("write_bus_idle", {24'd0, databus}, 32'h0000_00ff);
        @(negedge clk);
        iorw = 1'b1; ioaddr = 2'b01;
        #1 check("addr1_bus_idle", {24'd0, databus}, 32'h0000_00ff);
        @(negedge clk);
        iocs = 1'b0; ioaddr = 2'b00;
        #1 check("nocs_bus_idle", {24'd0, databus}, 32'h0000_00ff);
        @(negedge clk);
        check_flags("after_poke");
    endtask

    // Scoreboard monitor: compares each read against the expected-queue head.
    always @(negedge clk) begin
        #1;
        if (iocs && iorw && ioaddr == 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=%0h expected=none", databus);
            end else begin
                mon_e = exp_q.pop_front();
                check("read_data", {24'd0, databus}, {24'd0, mon_e[10:3]});
                check("read_rda",  {31'd0, rda},  {31'd0, mon_e[2]});
                check("read_ferr", {31'd0, ferr}, {31'd0, mon_e[1]});
                check("read_ovr",  {31'd0, ovr},  {31'd0, mon_e[0]});
            end
        end
    end

    // Watchdog: the run is time-bounded regardless of stimulus.
    initial begin
        #3000000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Main stimulus: directed scenarios, then randomized frames, then report.
    initial begin
        int          kind;
        logic [7:0]  d;
        rst      = 1'b1;
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = 2'b00;
        rxd      = 1'b1;
        brg_full = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_flags("reset");
        check("reset_bus_idle", {24'd0, databus}, 32'h0000_00ff);
        rst = 1'b0;
        @(negedge clk);
        check_flags("post_reset");
        do_read();

        // Single byte, then ignored accesses, then read.
        send_frame(8'h6a, 1'b1, 0, 0, 0);
        check_flags("t1");
        poke_ignored();
        do_read();

        // Back-to-back frames without a read: overrun.
        send_frame(8'h6a, 1'b1, 0, 0, 0);
        send_frame(8'hf3, 1'b1, 0, 0, 0);
        check_flags("t2");
        do_read();

        // Short glitch is rejected; the next frame is received.
        send_glitch(3);
        check_flags("t3_glitch");
        send_frame(8'h55, 1'b1, 0, 0, 0);
        do_read();

        // Framing error with a held-low line, then a valid frame.
        send_frame(8'ha5, 1'b0, 40, 0, 0);
        check_flags("t4_ferr");
        send_frame(8'h3c, 1'b1, 0, 0, 0);
        check_flags("t4_next");
        do_read();

        // Read coinciding with stop-bit completion.
        send_frame(8'h11, 1'b1, 0, 0, 0);
        send_frame(8'h22, 1'b1, 0, STOP_SAMPLE, 0);
        check_flags("t5");
        do_read();

        // Reset during data bit 4, then a clean frame.
        send_frame(8'hff, 1'b1, 0, 0, 5 * OS + 5);
        check_flags("t6_reset");
        check("t6_bus_idle", {24'd0, databus}, 32'h0000_00ff);
        send_frame(8'h81, 1'b1, 0, 0, 0);
        do_read();

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 9));
            d    = 8'($urandom_range(0, 255));
            if (kind == 0) send_glitch(int'($urandom_range(1, 6)));
            else if (kind == 1) send_frame(d, 1'b0, int'($urandom_range(5, 40)), 0, 0);
            else send_frame(d, 1'b1, 0, 0, 0);
            check_flags("rand");
            if ($urandom_range(0, 1) == 1) do_read();
        end
        do_read();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
